// File: rtl/dm_sram_responder.sv
// -----------------------------------------------------------------------------
// dm_sram_responder
//   Memory end of the core's DM port. This is a word-organised synchronous SRAM
//   with active-low byte-lane write enables and registered reads that return
//   data one cycle after the request. After reset, a sequencer can zero every
//   word before the array starts accepting accesses.
//
//   Ports
//     clk       clock; all state updates happen on posedge
//     rst_n     asynchronous active-low reset
//     DM_OE     read enable, sampled at posedge
//     DM_WEB    byte write enables, active low; bit i controls DM_DI[8i+7:8i]
//     DM_A      word address (ADDR_W bits)
//     DM_DI     write data, already lane-aligned by the core
//     DM_DO     registered read data
//     dm_ready  1 once the array accepts accesses
//     dm_err    sticky flag: an access with DM_A >= DEPTH was seen while ready
// -----------------------------------------------------------------------------
module dm_sram_responder #(
    parameter int unsigned ADDR_W     = 14,
    parameter int unsigned DEPTH      = 16384,
    parameter bit          INIT_CLEAR = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              DM_OE,
    input  logic [3:0]        DM_WEB,
    input  logic [ADDR_W-1:0] DM_A,
    input  logic [31:0]       DM_DI,
    output logic [31:0]       DM_DO,
    output logic              dm_ready,
    output logic              dm_err
);

    localparam int unsigned       IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_e;

    localparam state_e ST_RESET = INIT_CLEAR ? ST_CLEAR : ST_RUN;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic [31:0]       do_q;

    logic              in_range;
    logic              access;
    logic              rd_en;
    logic [3:0]        lane_we;
    logic [IDX_W-1:0]  wr_idx;
    logic [31:0]       wr_data;

    logic [31:0]       mem [DEPTH];

    // The clear sequencer takes over the write port; in RUN the port is driven by
    // the core, and out-of-range accesses are turned into an error with no write.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        err_d    = err_q;
        rd_en    = 1'b0;
        lane_we  = '0;
        wr_idx   = DM_A[IDX_W-1:0];
        wr_data  = DM_DI;
        in_range = ({1'b0, DM_A} < DEPTH_LIM);
        access   = DM_OE | (DM_WEB != 4'hF);

        case (state_q)
            ST_CLEAR: begin
                lane_we = '1;
                wr_idx  = ptr_q[IDX_W-1:0];
                wr_data = '0;
                if (ptr_q == PTR_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            ST_RUN: begin
                rd_en = DM_OE;
                if (in_range) begin
                    lane_we = ~DM_WEB;
                end else if (access) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = ST_RESET;
        endcase

        // Ready is registered from the next state, so it rises in the cycle
        // right after the last clear write.
        ready_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RESET;
            ptr_q   <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // The read uses the pre-edge array contents, so a same-address write in the
    // same cycle is returned as the old word (read-first).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            do_q <= '0;
        end else if (rd_en) begin
            do_q <= in_range ? mem[DM_A[IDX_W-1:0]] : '0;
        end
    end

    // The array has no reset; writes are suppressed while rst_n is held low.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (rst_n && lane_we[i]) begin
                mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    assign DM_DO    = do_q;
    assign dm_ready = ready_q;
    assign dm_err   = err_q;

endmodule

// File: tb/tb_dm_sram_responder.sv
// -----------------------------------------------------------------------------
// tb_dm_sram_responder
//   Bench for dm_sram_responder with DEPTH=16 and ADDR_W=5, so that
//   out-of-range addresses can be driven. A reference model counts clock edges
//   since reset: the first DEPTH edges clear the words, and after that each edge
//   is a read-first access to a plain word array. The outputs are compared with
//   the model on every falling edge, and directed sequences add literal
//   expectations.
// -----------------------------------------------------------------------------
module tb_dm_sram_responder;

    localparam int unsigned AW  = 5;
    localparam int          DEP = 16;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          DM_OE  = 1'b0;
    logic [3:0]    DM_WEB = 4'hF;
    logic [AW-1:0] DM_A   = '0;
    logic [31:0]   DM_DI  = '0;
    logic [31:0]   DM_DO;
    logic          dm_ready;
    logic          dm_err;

    int checks = 0;
    int passes = 0;

    dm_sram_responder #(
        .ADDR_W    (AW),
        .DEPTH     (DEP),
        .INIT_CLEAR(1'b1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .DM_OE   (DM_OE),
        .DM_WEB  (DM_WEB),
        .DM_A    (DM_A),
        .DM_DI   (DM_DI),
        .DM_DO   (DM_DO),
        .dm_ready(dm_ready),
        .dm_err  (dm_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_mem [DEP];
    logic [31:0] m_do   = '0;
    logic        m_err  = 1'b0;
    int          m_edges = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_edges = 0;
            m_do    = '0;
            m_err   = 1'b0;
        end else if (m_edges < DEP) begin
            m_mem[m_edges[3:0]] = '0;
            m_edges++;
        end else begin
            if (DM_OE) m_do = (DM_A < DEP) ? m_mem[DM_A[3:0]] : 32'h0;
            if (DM_WEB != 4'hF && DM_A < DEP) begin
                for (int b = 0; b < 4; b++)
                    if (!DM_WEB[b]) m_mem[DM_A[3:0]][8*b +: 8] = DM_DI[8*b +: 8];
            end
            if ((DM_OE || DM_WEB != 4'hF) && DM_A >= DEP) m_err = 1'b1;
        end
    end

    always @(negedge clk) begin
        check("model_do", DM_DO, m_do);
        check("model_ready", {31'b0, dm_ready}, {31'b0, (m_edges >= DEP)});
        check("model_err", {31'b0, dm_err}, {31'b0, m_err});
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic oe, input logic [3:0] web, input logic [AW-1:0] a,
                       input logic [31:0] di);
        DM_OE  = oe;
        DM_WEB = web;
        DM_A   = a;
        DM_DI  = di;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 4'hF, '0, '0);
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!dm_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, n, 32'd16);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        check("reset_do", DM_DO, 32'h0);
        check("reset_ready", {31'b0, dm_ready}, 32'h0);
        check("reset_err", {31'b0, dm_err}, 32'h0);

        // 1: clear sequence
        rst_n = 1'b1;
        wait_ready("clear_cycles");
        cyc(1'b1, 4'hF, 5'd9, '0);   check("clear_rd9", DM_DO, 32'h0);
        cyc(1'b1, 4'hF, 5'd15, '0);  check("clear_rd15", DM_DO, 32'h0);

        // 2: byte lanes
        cyc(1'b0, 4'b0000, 5'd5, 32'hAABBCCDD);
        cyc(1'b0, 4'b1101, 5'd5, 32'h11223344);
        cyc(1'b1, 4'hF, 5'd5, '0);   check("lane_merge", DM_DO, 32'hAABB33DD);

        // 3: read-first
        cyc(1'b0, 4'b0000, 5'd7, 32'h1);
        cyc(1'b1, 4'b0000, 5'd7, 32'h2); check("read_first_old", DM_DO, 32'h1);
        cyc(1'b1, 4'hF, 5'd7, '0);       check("read_first_new", DM_DO, 32'h2);

        // 4: back-to-back reads, then hold
        cyc(1'b0, 4'b0000, 5'd1, 32'h01010101);
        cyc(1'b0, 4'b0000, 5'd2, 32'h02020202);
        cyc(1'b0, 4'b0000, 5'd3, 32'h03030303);
        cyc(1'b1, 4'hF, 5'd1, '0);   check("b2b_rd1", DM_DO, 32'h01010101);
        cyc(1'b1, 4'hF, 5'd2, '0);   check("b2b_rd2", DM_DO, 32'h02020202);
        cyc(1'b1, 4'hF, 5'd3, '0);   check("b2b_rd3", DM_DO, 32'h03030303);
        idle();
        idle();                      check("hold_rd3", DM_DO, 32'h03030303);

        // every write-enable pattern on one word, checked by the model
        for (int p = 0; p < 16; p++) begin
            cyc(1'b0, 4'(p), 5'd10, 32'(32'h01020304 * (p + 1)));
            cyc(1'b1, 4'hF, 5'd10, '0);
        end

        // 5: out of range (20 would alias word 4 if the upper bit were dropped)
        cyc(1'b0, 4'b0000, 5'd4, 32'h44444444);
        check("range_err_before", {31'b0, dm_err}, 32'h0);
        cyc(1'b0, 4'b0000, 5'd20, 32'hDEADBEEF);
        check("range_err_set", {31'b0, dm_err}, 32'h1);
        cyc(1'b1, 4'hF, 5'd4, '0);   check("range_rd4", DM_DO, 32'h44444444);
        cyc(1'b1, 4'hF, 5'd20, '0);  check("range_rd20", DM_DO, 32'h0);
        idle();
        idle();                      check("range_err_sticky", {31'b0, dm_err}, 32'h1);

        // 6a: reset during RUN drops an in-flight read result
        cyc(1'b1, 4'hF, 5'd5, '0);   check("pre_reset_rd5", DM_DO, 32'hAABB33DD);
        DM_OE  = 1'b0;
        DM_WEB = 4'hF;
        #2 rst_n = 1'b0;
        #1;
        check("run_reset_do", DM_DO, 32'h0);
        check("run_reset_ready", {31'b0, dm_ready}, 32'h0);
        check("run_reset_err", {31'b0, dm_err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // 6b: reset mid-clear at pointer 8
        repeat (8) @(negedge clk);
        check("mid_clear_not_ready", {31'b0, dm_ready}, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check("clear_reset_do", DM_DO, 32'h0);
        check("clear_reset_ready", {31'b0, dm_ready}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("reclear_cycles");
        cyc(1'b1, 4'hF, 5'd5, '0);   check("reclear_rd5", DM_DO, 32'h0);
        idle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
